// File: rtl/clock_set_controller.sv
// clock_set_controller: debounces MODE/ADJ keys and sequences RUN->HOUR->MIN->SEC field setting.
// Define AUTO_REPEAT_EN to enable auto-repeat of ADJ increment pulses while the key is held.
module clock_set_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_adj_n,
    output logic [1:0] set,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       running
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // State codes double as the field-select value driven on set.
    localparam logic [1:0] ST_SEC  = 2'd0;
    localparam logic [1:0] ST_MIN  = 2'd1;
    localparam logic [1:0] ST_HOUR = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    // Index 0 = MODE key, index 1 = ADJ key.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_nxt;
    logic            mode_press;
    logic            adj_press;
    logic            in_set;
    logic            adj_pulse;
    logic            rpt_fire;
    logic            timeout;
    logic            pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            press <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {key_adj_n, key_mode_n};
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign mode_press = press[0];
    assign adj_press  = press[1];
    assign in_set     = (state != ST_RUN);
    assign adj_pulse  = adj_press && !mode_press && in_set;
    assign pulse      = adj_pulse || rpt_fire;
    assign timeout    = in_set && !mode_press && !adj_press && !rpt_fire && (to_cnt == TO_LAST);
    assign to_nxt     = (!in_set || mode_press || adj_press || rpt_fire || timeout) ? '0 : to_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        if (mode_press) begin
            case (state)
                ST_RUN:  state_nxt = ST_HOUR;
                ST_HOUR: state_nxt = ST_MIN;
                ST_MIN:  state_nxt = ST_SEC;
                default: state_nxt = ST_RUN;
            endcase
        end else if (timeout) begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            to_cnt   <= '0;
            running  <= 1'b1;
            inc_hour <= 1'b0;
            inc_min  <= 1'b0;
            inc_sec  <= 1'b0;
        end else begin
            state    <= state_nxt;
            to_cnt   <= to_nxt;
            running  <= (state_nxt == ST_RUN);
            inc_hour <= pulse && (state == ST_HOUR);
            inc_min  <= pulse && (state == ST_MIN);
            inc_sec  <= pulse && (state == ST_SEC);
        end
    end

    assign set = state;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic            rpt_active;
    logic [RP_W-1:0] rpt_cnt;

    // Reloading to DELAY-PERIOD lets one terminal compare serve both the first delay and the period.
    assign rpt_fire = rpt_active && !deb[1] && in_set && !mode_press && !adj_press && (rpt_cnt == RP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_active <= 1'b0;
            rpt_cnt    <= '0;
        end else if (adj_pulse) begin
            rpt_active <= 1'b1;
            rpt_cnt    <= '0;
        end else if (mode_press || !in_set || deb[1] || timeout) begin
            rpt_active <= 1'b0;
            rpt_cnt    <= '0;
        end else if (rpt_fire) begin
            rpt_cnt <= RP_RELOAD;
        end else if (rpt_active) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    logic unused_repeat_cfg;

    assign rpt_fire          = 1'b0;
    assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
`endif

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: cycle-accurate reference model plus directed and random key stimulus.
module tb_clock_set_controller;

    localparam int DB = 4;
    localparam int TO = 100;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD60_PULSES = 6;
`else
    localparam int HOLD60_PULSES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_adj_n = 1'b1;
    logic [1:0] set;
    logic       inc_sec;
    logic       inc_min;
    logic       inc_hour;
    logic       running;

    int checks = 0;
    int errors = 0;
    int n_hour = 0;
    int n_min = 0;
    int n_sec = 0;

    always #5 clk = ~clk;

    clock_set_controller #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode_n(key_mode_n),
        .key_adj_n (key_adj_n),
        .set       (set),
        .inc_sec   (inc_sec),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .running   (running)
    );

    // Reference model: fld 0=RUN 1=HOUR 2=MIN 3=SEC; activity timestamps instead of counters.
    int       cyc = 0;
    int       fld = 0;
    bit       ms1 [2];
    bit       ms2 [2];
    bit       mdeb [2];
    bit       mpress [2];
    int       mrun [2];
    int       last_act = 0;
    bit       rep_on = 1'b0;
    int       next_due = 0;
    bit [2:0] exp_inc = 3'b000;   // {hour, min, sec}

    always @(posedge clk) begin : model
        bit adj_lvl;
        cyc++;
        if (!rst_n) begin
            fld      = 0;
            exp_inc  = 3'b000;
            rep_on   = 1'b0;
            last_act = cyc;
            for (int k = 0; k < 2; k++) begin
                ms1[k] = 1'b1; ms2[k] = 1'b1; mdeb[k] = 1'b1;
                mpress[k] = 1'b0; mrun[k] = 0;
            end
        end else begin
            adj_lvl = mdeb[1];
            exp_inc = 3'b000;
            if (mpress[0]) begin
                fld      = (fld + 1) % 4;
                last_act = cyc;
                rep_on   = 1'b0;
            end else if (mpress[1]) begin
                last_act = cyc;
                if (fld != 0) begin
                    exp_inc[3 - fld] = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rep_on   = 1'b1;
                    next_due = cyc + RD;
`endif
                end
            end else if (fld != 0 && rep_on && !adj_lvl && cyc == next_due) begin
                exp_inc[3 - fld] = 1'b1;
                last_act = cyc;
                next_due = cyc + RP;
            end else if (fld != 0 && cyc - last_act == TO) begin
                fld = 0;
            end
            if (adj_lvl || fld == 0) rep_on = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mpress[k] = 1'b0;
                if (ms2[k] == mdeb[k]) begin
                    mrun[k] = 0;
                end else begin
                    mrun[k]++;
                    if (mrun[k] == DB) begin
                        mdeb[k]   = ms2[k];
                        mrun[k]   = 0;
                        mpress[k] = !ms2[k];
                    end
                end
            end
            ms2    = ms1;
            ms1[0] = key_mode_n;
            ms1[1] = key_adj_n;
        end
    end

    always @(negedge clk) begin : compare
        logic [5:0] act;
        logic [5:0] req;
        act = {set, running, inc_hour, inc_min, inc_sec};
        if (!rst_n) req = {2'd3, 1'b1, 3'b000};
        else        req = {((fld == 0) ? 2'd3 : 2'(3 - fld)), (fld == 0), exp_inc};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL outputs cyc=%0d actual={set,run,h,m,s}=%b required=%b", cyc, act, req);
        end
        checks++;
        if ($countones({inc_hour, inc_min, inc_sec}) > 1 || (running && (inc_hour || inc_min || inc_sec))) begin
            errors++;
            $display("FAIL pulse_rule cyc=%0d actual run=%b h=%b m=%b s=%b required at most one pulse and none in RUN",
                     cyc, running, inc_hour, inc_min, inc_sec);
        end
        n_hour += int'(inc_hour);
        n_min  += int'(inc_min);
        n_sec  += int'(inc_sec);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic hit(input bit is_adj, input int hold, input int gap);
        if (is_adj) key_adj_n = 1'b0;
        else        key_mode_n = 1'b0;
        tick(hold);
        key_adj_n  = 1'b1;
        key_mode_n = 1'b1;
        tick(gap);
    endtask

    function automatic int total();
        return n_hour + n_min + n_sec;
    endfunction

    initial begin
        int lat;
        int t0;
        int r;

        // Reset with keys chattering
        tick(1);
        for (int i = 0; i < 10; i++) begin
            key_mode_n = 1'($urandom);
            key_adj_n  = 1'($urandom);
            tick(1);
        end
        lit("reset_set", int'(set), 3);
        lit("reset_running", int'(running), 1);
        lit("reset_inc", int'({inc_hour, inc_min, inc_sec}), 0);
        key_mode_n = 1'b1;
        key_adj_n  = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        lit("post_reset_set", int'(set), 3);
        lit("post_reset_running", int'(running), 1);

        // Short glitches must be rejected
        for (int i = 0; i < 5; i++) hit(1'b0, 3, 3);
        tick(10);
        lit("bounce_set", int'(set), 3);

        // Clean press: latency from raw edge to set change
        key_mode_n = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick(1);
            if (set != 2'd3) lat = i;
        end
        if (lat < 10) tick(10 - lat);
        key_mode_n = 1'b1;
        tick(10);
        lit("mode_latency", lat, 7);
        lit("hour_set", int'(set), 2);
        lit("hour_running", int'(running), 0);

        // ADJ in each SET state, then in RUN
        t0 = n_hour; hit(1'b1, 8, 8); lit("adj_hour", n_hour - t0, 1);
        hit(1'b0, 8, 8); lit("min_set", int'(set), 1);
        t0 = n_min;  hit(1'b1, 8, 8); lit("adj_min", n_min - t0, 1);
        hit(1'b0, 8, 8); lit("sec_set", int'(set), 0);
        t0 = n_sec;  hit(1'b1, 8, 8); lit("adj_sec", n_sec - t0, 1);
        hit(1'b0, 8, 8); lit("run_set", int'(set), 3);
        t0 = total(); hit(1'b1, 8, 8); lit("adj_run_none", total() - t0, 0);

        // MODE and ADJ together: MODE wins
        hit(1'b0, 8, 8);
        t0 = total();
        key_mode_n = 1'b0;
        key_adj_n  = 1'b0;
        tick(8);
        key_mode_n = 1'b1;
        key_adj_n  = 1'b1;
        tick(8);
        lit("simul_set", int'(set), 1);
        lit("simul_no_pulse", total() - t0, 0);

        // Timeout: set changes 7 cycles into hit(); hit() returns 16 cycles after its edge
        hit(1'b0, 8, 8); hit(1'b0, 8, 8); hit(1'b0, 8, 8); hit(1'b0, 8, 8);
        tick(TO - 10);
        lit("timeout_pre", int'(set), 1);
        tick(1);
        lit("timeout_set", int'(set), 3);
        lit("timeout_running", int'(running), 1);

        // ADJ press landing on the last idle cycle beats the timeout and restarts it
        hit(1'b0, 8, 8); hit(1'b0, 8, 8);
        tick(TO - 16);
        t0 = n_min;
        key_adj_n = 1'b0;
        tick(8);
        lit("late_adj_pulse", n_min - t0, 1);
        lit("late_adj_set", int'(set), 1);
        key_adj_n = 1'b1;
        tick(8);
        tick(TO - 10);
        lit("restart_pre", int'(set), 1);
        tick(1);
        lit("restart_set", int'(set), 3);

        // Long ADJ hold in SET_SEC
        hit(1'b0, 8, 8); hit(1'b0, 8, 8); hit(1'b0, 8, 8);
        t0 = n_sec;
        key_adj_n = 1'b0;
        tick(60);
        key_adj_n = 1'b1;
        tick(20);
        lit("hold60_pulses", n_sec - t0, HOLD60_PULSES);
        hit(1'b0, 8, 8);
        lit("hold60_back_run", int'(set), 3);

        // Random key activity, checked every cycle by the model
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: hit(1'b0, int'($urandom_range(1, 14)), int'($urandom_range(1, 10)));
                3, 4, 5, 6: hit(1'b1, int'($urandom_range(1, 50)), int'($urandom_range(1, 10)));
                7: begin
                    key_mode_n = 1'b0;
                    key_adj_n  = 1'b0;
                    tick(int'($urandom_range(1, 12)));
                    key_mode_n = 1'b1;
                    tick(int'($urandom_range(0, 6)));
                    key_adj_n  = 1'b1;
                    tick(int'($urandom_range(1, 10)));
                end
                8: tick(int'($urandom_range(20, 130)));
                default: begin
                    key_mode_n = 1'($urandom);
                    key_adj_n  = 1'($urandom);
                    tick(int'($urandom_range(1, 6)));
                    rst_n = 1'b0;
                    tick(int'($urandom_range(1, 3)));
                    rst_n = 1'b1;
                    tick(int'($urandom_range(1, 10)));
                    key_mode_n = 1'b1;
                    key_adj_n  = 1'b1;
                    tick(10);
                end
            endcase
        end
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
